fdc_seek_ctrl: RTL and testbench
================================

// Module: fdc_seek_ctrl
// PURPOSE
// Controller-side head-positioning and motor sequencer; drives the floppy drive model's select/motor/step inputs.
// Executes restore, seek, step-in and step-out commands: step pulses at the programmed rate, motor spin-up and
// spin-down by index count, optional post-seek settle/ready verify. Sits between FDC command decode and the drive.
// PARAMETERS
// SYS_CLK          8000000  clock frequency (Hz); all timings derived from it
// STEP_PULSE_US    4        step pulse high time (us) -> STEP_PULSE_CLKS = SYS_CLK/1000000*STEP_PULSE_US
// SETTLE_MS        15       head settle time before ready check when verify=1
// SPINUP_INDEX     6        index rising edges to wait after motor-on when spinup_en=1
// MOTOR_OFF_INDEX  9        idle index rising edges before motor_on drops
// RESTORE_LIMIT    255      max step pulses during restore before error
// VERIFY_INDEX     5        index edges allowed for fd_ready during verify
// PORTS
// clk             in   1  system clock
// reset           in   1  asynchronous, active-high reset
// cmd_start       in   1  1-cycle command strobe; ignored while busy
// cmd_type        in   2  0 restore, 1 seek, 2 step_in (toward track 0), 3 step_out
// target_track    in   7  seek destination (cmd_type 1 only)
// step_rate       in   2  0 6ms, 1 12ms, 2 2ms, 3 3ms (pulse rising edge to next rising edge)
// spinup_en       in   1  wait SPINUP_INDEX edges if motor was off at command start
// verify          in   1  after final step wait SETTLE_MS then fd_ready
// fd_index        in   1  drive index pulse (level)
// fd_track0       in   1  drive head at track 0
// fd_ready        in   1  drive ready
// fd_select       out  1  drive select
// fd_motor_on     out  1  motor enable
// fd_step_in      out  1  step pulse toward track 0
// fd_step_out     out  1  step pulse away from track 0
// track_reg       out  7  controller track register
// busy            out  1  command in progress
// done            out  1  1-cycle pulse at command completion (with or without error)
// err_track0      out  1  restore exhausted RESTORE_LIMIT; cleared at next cmd_start
// err_not_ready   out  1  verify timed out; cleared at next cmd_start
// BEHAVIOUR
// - Reset (async): all outputs 0, track_reg 0, state IDLE, all counters 0.
// - fd_index, fd_track0, fd_ready registered once; index event = rising edge of registered fd_index.
// - States: IDLE, SPINUP, CHECK, PULSE, STEPWAIT, SETTLE, VERIFY, FINISH.
// - IDLE + cmd_start: latch inputs, busy=1, fd_select=1, fd_motor_on=1, clear errs and idle index count;
//   -> SPINUP if motor was off and spinup_en, else CHECK.
// - SPINUP: count index events; at SPINUP_INDEX -> CHECK.
// - CHECK: restore: fd_track0=1 -> track_reg=0, FINISH; pulse count==RESTORE_LIMIT -> err_track0=1, FINISH; else step_in.
//   seek: track_reg==target -> SETTLE if verify else FINISH; target<track_reg -> step_in, else step_out.
//   step_in/step_out commands: one pulse only; step_in with fd_track0=1 issues no pulse, track_reg=0.
// - PULSE: selected step output high exactly STEP_PULSE_CLKS cycles; track_reg +/-1 on entry (saturate 0 and 127;
//   restore does not modify track_reg until track0 seen) -> STEPWAIT.
// - STEPWAIT: wait until step period (from pulse rising edge) elapses; then seek/restore -> CHECK,
//   single step -> SETTLE if verify else FINISH.
// - SETTLE: SETTLE_MS*SYS_CLK/1000 cycles -> VERIFY. VERIFY: fd_ready=1 -> FINISH; VERIFY_INDEX index events
//   first -> err_not_ready=1, FINISH.
// - FINISH: done=1 one cycle, busy=0, -> IDLE. Step outputs never both high; never high outside PULSE.
// - Motor: in IDLE with motor on, count index events; at MOTOR_OFF_INDEX drop fd_motor_on and fd_select.
// - Timing counters 20 bits minimum; step period clocks = SYS_CLK/1000*ms.
// - Reset mid-step: step output low immediately, no resume.
// TESTING (SYS_CLK 8 MHz: pulse = 32 clks, 6 ms = 48000 clks)
// restore, track0 rises after 3rd pulse, rate 0 -> exactly 3 step_in pulses 32 clks wide, 48000 apart; track_reg 0; done.
// track_reg 10, seek 13, rate 2 -> 3 step_out pulses 16000 apart, track_reg 13, done, no errors.
// restore, fd_track0 held 0 -> 255 step_in pulses, err_track0=1, done; next cmd_start clears err.
// motor off, spinup_en=1, seek 0->2 -> motor_on at once, first pulse after 6th index edge; 9 idle index edges -> motor_on 0.
// seek 5->6, verify=1, fd_ready held 0 -> settle 120000 clks then err_not_ready after 5 index edges.
// seek to current track -> no pulse, done within 4 clks; cmd_start while busy ignored; reset mid-pulse -> step low async.

Source files
------------

// File: rtl/fdc_seek_ctrl_if.sv
// Command/status channel between FDC command decode and the seek controller.
//   master : command decoder (drives the command fields, reads status)
//   slave  : fdc_seek_ctrl   (reads the command fields, drives status)
// Signals:
//   cmd_start     1-cycle command strobe, ignored while the controller is busy
//   cmd_type      0 restore, 1 seek, 2 step_in (toward track 0), 3 step_out
//   target_track  seek destination
//   step_rate     0 6ms, 1 12ms, 2 2ms, 3 3ms step period
//   spinup_en     wait for spin-up index edges if the motor was off
//   verify        settle and wait for drive ready after the last step
//   track_reg     controller track register
//   busy/done     command in progress / 1-cycle completion pulse
//   err_track0    restore never saw track 0
//   err_not_ready verify timed out waiting for drive ready
interface fdc_seek_ctrl_if;
  logic       cmd_start;
  logic [1:0] cmd_type;
  logic [6:0] target_track;
  logic [1:0] step_rate;
  logic       spinup_en;
  logic       verify;
  logic [6:0] track_reg;
  logic       busy;
  logic       done;
  logic       err_track0;
  logic       err_not_ready;

  modport master (
    output cmd_start, cmd_type, target_track, step_rate, spinup_en, verify,
    input  track_reg, busy, done, err_track0, err_not_ready
  );

  modport slave (
    input  cmd_start, cmd_type, target_track, step_rate, spinup_en, verify,
    output track_reg, busy, done, err_track0, err_not_ready
  );
endinterface

// File: rtl/fdc_seek_ctrl.sv
// Floppy controller head-positioning and motor sequencer.
// Runs restore / seek / step_in / step_out commands against the drive: motor
// spin-up by index count, step pulses at the programmed rate, optional settle
// and ready verify, and motor spin-down after idle index revolutions.
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   host (slave)         command strobe/fields in, track/busy/done/errors out
//   fd_index/track0/ready drive status inputs (registered once here)
//   fd_select/motor_on   drive select and spindle motor enable
//   fd_step_in/out       step pulses toward / away from track 0
module fdc_seek_ctrl #(
  parameter int unsigned SYS_CLK         = 8000000,
  parameter int unsigned STEP_PULSE_US   = 4,
  parameter int unsigned SETTLE_MS       = 15,
  parameter int unsigned SPINUP_INDEX    = 6,
  parameter int unsigned MOTOR_OFF_INDEX = 9,
  parameter int unsigned RESTORE_LIMIT   = 255,
  parameter int unsigned VERIFY_INDEX    = 5
) (
  input  logic           clk,
  input  logic           reset,
  fdc_seek_ctrl_if.slave host,
  input  logic           fd_index,
  input  logic           fd_track0,
  input  logic           fd_ready,
  output logic           fd_select,
  output logic           fd_motor_on,
  output logic           fd_step_in,
  output logic           fd_step_out
);

  localparam int unsigned CNT_W  = 24;
  localparam int unsigned ICNT_W = 8;
  localparam int unsigned PCNT_W = (RESTORE_LIMIT < 1) ? 1 : $clog2(RESTORE_LIMIT + 1);

  localparam logic [CNT_W-1:0] PULSE_CLKS  = CNT_W'(SYS_CLK / 1000000 * STEP_PULSE_US);
  localparam logic [CNT_W-1:0] SETTLE_CLKS = CNT_W'(SETTLE_MS * SYS_CLK / 1000);
  localparam logic [CNT_W-1:0] PER_6MS     = CNT_W'(SYS_CLK / 1000 * 6);
  localparam logic [CNT_W-1:0] PER_12MS    = CNT_W'(SYS_CLK / 1000 * 12);
  localparam logic [CNT_W-1:0] PER_2MS     = CNT_W'(SYS_CLK / 1000 * 2);
  localparam logic [CNT_W-1:0] PER_3MS     = CNT_W'(SYS_CLK / 1000 * 3);

  localparam logic [ICNT_W-1:0] SPINUP_LAST = ICNT_W'(SPINUP_INDEX - 1);
  localparam logic [ICNT_W-1:0] MOTOR_LAST  = ICNT_W'(MOTOR_OFF_INDEX - 1);
  localparam logic [ICNT_W-1:0] VERIFY_LAST = ICNT_W'(VERIFY_INDEX - 1);
  localparam logic [PCNT_W-1:0] PULSE_LIMIT = PCNT_W'(RESTORE_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE, S_SPINUP, S_CHECK, S_PULSE, S_STEPWAIT, S_SETTLE, S_VERIFY, S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    C_RESTORE, C_SEEK, C_STEP_IN, C_STEP_OUT
  } cmd_t;

  state_t state, state_n;

  logic idx_q, idx_prev, trk0_q, rdy_q;
  logic idx_ev;

  cmd_t        cmd_q,    cmd_n;
  logic [6:0]  target_q, target_n;
  logic [1:0]  rate_q,   rate_n;
  logic        verify_q, verify_n;
  logic [6:0]  track_q,  track_n;
  logic        dir_in_q, dir_in_n;
  logic [CNT_W-1:0]  tcnt, tcnt_n;
  logic [PCNT_W-1:0] pcnt, pcnt_n;
  logic [ICNT_W-1:0] icnt, icnt_n;
  logic motor_q,  motor_n;
  logic select_q, select_n;
  logic err_t0_q, err_t0_n;
  logic err_nr_q, err_nr_n;

  logic [CNT_W-1:0] period;
  logic [6:0] track_dec, track_inc;

  // Drive status inputs are registered once; the index event is the rising
  // edge of the registered index level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q    <= 1'b0;
      idx_prev <= 1'b0;
      trk0_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      idx_q    <= fd_index;
      idx_prev <= idx_q;
      trk0_q   <= fd_track0;
      rdy_q    <= fd_ready;
    end
  end

  assign idx_ev = idx_q & ~idx_prev;

  always_comb begin
    period = PER_6MS;
    case (rate_q)
      2'd0:    period = PER_6MS;
      2'd1:    period = PER_12MS;
      2'd2:    period = PER_2MS;
      default: period = PER_3MS;
    endcase
  end

  assign track_dec = (track_q == 7'd0)   ? 7'd0   : track_q - 7'd1;
  assign track_inc = (track_q == 7'd127) ? 7'd127 : track_q + 7'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cmd_q    <= C_RESTORE;
      target_q <= '0;
      rate_q   <= '0;
      verify_q <= 1'b0;
      track_q  <= '0;
      dir_in_q <= 1'b0;
      tcnt     <= '0;
      pcnt     <= '0;
      icnt     <= '0;
      motor_q  <= 1'b0;
      select_q <= 1'b0;
      err_t0_q <= 1'b0;
      err_nr_q <= 1'b0;
    end else begin
      state    <= state_n;
      cmd_q    <= cmd_n;
      target_q <= target_n;
      rate_q   <= rate_n;
      verify_q <= verify_n;
      track_q  <= track_n;
      dir_in_q <= dir_in_n;
      tcnt     <= tcnt_n;
      pcnt     <= pcnt_n;
      icnt     <= icnt_n;
      motor_q  <= motor_n;
      select_q <= select_n;
      err_t0_q <= err_t0_n;
      err_nr_q <= err_nr_n;
    end
  end

  always_comb begin
    state_n  = state;
    cmd_n    = cmd_q;
    target_n = target_q;
    rate_n   = rate_q;
    verify_n = verify_q;
    track_n  = track_q;
    dir_in_n = dir_in_q;
    tcnt_n   = tcnt;
    pcnt_n   = pcnt;
    icnt_n   = icnt;
    motor_n  = motor_q;
    select_n = select_q;
    err_t0_n = err_t0_q;
    err_nr_n = err_nr_q;

    case (state)
      S_IDLE: begin
        if (host.cmd_start) begin
          cmd_n    = cmd_t'(host.cmd_type);
          target_n = host.target_track;
          rate_n   = host.step_rate;
          verify_n = host.verify;
          motor_n  = 1'b1;
          select_n = 1'b1;
          err_t0_n = 1'b0;
          err_nr_n = 1'b0;
          icnt_n   = '0;
          pcnt_n   = '0;
          tcnt_n   = '0;
          state_n  = (!motor_q && host.spinup_en) ? S_SPINUP : S_CHECK;
        end else if (motor_q && idx_ev) begin
          if (icnt == MOTOR_LAST) begin
            motor_n  = 1'b0;
            select_n = 1'b0;
            icnt_n   = '0;
          end else begin
            icnt_n = icnt + ICNT_W'(1);
          end
        end
      end

      S_SPINUP: begin
        if (idx_ev) begin
          if (icnt == SPINUP_LAST) begin
            icnt_n  = '0;
            state_n = S_CHECK;
          end else begin
            icnt_n = icnt + ICNT_W'(1);
          end
        end
      end

      S_CHECK: begin
        tcnt_n = '0;
        case (cmd_q)
          C_RESTORE: begin
            // Track 0 wins over the pulse limit, so a head exactly
            // RESTORE_LIMIT steps out still restores cleanly.
            if (trk0_q) begin
              track_n = '0;
              state_n = S_FINISH;
            end else if (pcnt == PULSE_LIMIT) begin
              err_t0_n = 1'b1;
              state_n  = S_FINISH;
            end else begin
              dir_in_n = 1'b1;
              pcnt_n   = pcnt + PCNT_W'(1);
              state_n  = S_PULSE;
            end
          end
          C_SEEK: begin
            if (track_q == target_q) begin
              state_n = verify_q ? S_SETTLE : S_FINISH;
            end else if (target_q < track_q) begin
              dir_in_n = 1'b1;
              track_n  = track_dec;
              state_n  = S_PULSE;
            end else begin
              dir_in_n = 1'b0;
              track_n  = track_inc;
              state_n  = S_PULSE;
            end
          end
          C_STEP_IN: begin
            if (trk0_q) begin
              track_n = '0;
              state_n = verify_q ? S_SETTLE : S_FINISH;
            end else begin
              dir_in_n = 1'b1;
              track_n  = track_dec;
              state_n  = S_PULSE;
            end
          end
          default: begin
            dir_in_n = 1'b0;
            track_n  = track_inc;
            state_n  = S_PULSE;
          end
        endcase
      end

      S_PULSE: begin
        tcnt_n = tcnt + CNT_W'(1);
        if (tcnt == PULSE_CLKS - CNT_W'(1)) state_n = S_STEPWAIT;
      end

      S_STEPWAIT: begin
        // tcnt keeps running from the pulse rising edge. Leaving one cycle
        // early absorbs the CHECK cycle, so rising edges are exactly one
        // period apart.
        tcnt_n = tcnt + CNT_W'(1);
        if (tcnt >= period - CNT_W'(2)) begin
          tcnt_n = '0;
          if (cmd_q == C_RESTORE || cmd_q == C_SEEK) state_n = S_CHECK;
          else state_n = verify_q ? S_SETTLE : S_FINISH;
        end
      end

      S_SETTLE: begin
        tcnt_n = tcnt + CNT_W'(1);
        if (tcnt == SETTLE_CLKS - CNT_W'(1)) begin
          tcnt_n  = '0;
          icnt_n  = '0;
          state_n = S_VERIFY;
        end
      end

      S_VERIFY: begin
        if (rdy_q) begin
          state_n = S_FINISH;
        end else if (idx_ev) begin
          if (icnt == VERIFY_LAST) begin
            err_nr_n = 1'b1;
            state_n  = S_FINISH;
          end else begin
            icnt_n = icnt + ICNT_W'(1);
          end
        end
      end

      S_FINISH: begin
        icnt_n  = '0;
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  // Step outputs decode straight from the state register, so an async reset
  // drops them immediately and they can only be high in PULSE.
  assign fd_step_in  = (state == S_PULSE) &&  dir_in_q;
  assign fd_step_out = (state == S_PULSE) && !dir_in_q;
  assign fd_select   = select_q;
  assign fd_motor_on = motor_q;

  assign host.track_reg     = track_q;
  assign host.busy          = (state != S_IDLE) && (state != S_FINISH);
  assign host.done          = (state == S_FINISH);
  assign host.err_track0    = err_t0_q;
  assign host.err_not_ready = err_nr_q;

endmodule

// File: tb/tb_fdc_seek_ctrl.sv
// Testbench for fdc_seek_ctrl with a behavioural drive/head model.
// Scaled timing: 1 MHz clock -> 4-clk step pulse, 2 ms = 2000 clks, 1000-clk settle.
module tb_fdc_seek_ctrl;
  localparam int SYS     = 1000000;
  localparam int PW      = SYS / 1000000 * 4;
  localparam int SETTLE  = 1 * SYS / 1000;
  localparam int LIMIT   = 5;
  localparam int IDX_PER = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fd_index = 1'b0;
  logic fd_track0;
  logic fd_ready = 1'b0;
  logic fd_select, fd_motor_on, fd_step_in, fd_step_out;

  fdc_seek_ctrl_if host();

  fdc_seek_ctrl #(
    .SYS_CLK(SYS), .STEP_PULSE_US(4), .SETTLE_MS(1), .SPINUP_INDEX(6),
    .MOTOR_OFF_INDEX(9), .RESTORE_LIMIT(LIMIT), .VERIFY_INDEX(5)
  ) dut (
    .clk(clk), .reset(reset), .host(host),
    .fd_index(fd_index), .fd_track0(fd_track0), .fd_ready(fd_ready),
    .fd_select(fd_select), .fd_motor_on(fd_motor_on),
    .fd_step_in(fd_step_in), .fd_step_out(fd_step_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive head model and step-pulse recorder.
  int head = 0, head_base = 0, head_epoch = 0, head_seen = 0;
  logic trk0_block = 1'b0;
  int rt[$], rd[$], ri[$], wq[$];
  int wcnt = 0, both_hi = 0, idx_rises = 0;
  logic prev_step = 1'b0, step_now;
  assign fd_track0 = (head == 0) && !trk0_block;

  always @(negedge clk) begin
    if (head_epoch != head_seen) begin
      head = head_base;
      head_seen = head_epoch;
    end
    step_now = fd_step_in | fd_step_out;
    if (fd_step_in && fd_step_out) both_hi++;
    if (step_now && !prev_step) begin
      rt.push_back(cyc);
      rd.push_back(int'(fd_step_in));
      ri.push_back(idx_rises);
      if (fd_step_in) head = (head > 0) ? head - 1 : 0;
      else head = (head < 127) ? head + 1 : 127;
      wcnt = 0;
    end
    if (step_now) wcnt++;
    if (!step_now && prev_step) wq.push_back(wcnt);
    prev_step = step_now;
  end

  // Index pulse generator: 4 clks high every IDX_PER clks while enabled.
  logic idx_run = 1'b0;
  int idx_ph = 0;
  always @(negedge clk) begin
    if (idx_run) idx_ph = (idx_ph == IDX_PER - 1) ? 0 : idx_ph + 1;
    else idx_ph = 0;
    if (idx_run && idx_ph >= 1 && idx_ph <= 4) begin
      if (!fd_index) idx_rises++;
      fd_index = 1'b1;
    end else begin
      fd_index = 1'b0;
    end
  end

  function automatic int per_of(input int rate);
    int ms[4] = '{6, 12, 2, 3};
    return SYS / 1000 * ms[rate];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sync_head(input int h);
    head_base = h;
    head_epoch++;
  endtask

  task automatic start_cmd(input int typ, input int tgt, input int rate, input int spin, input int ver);
    @(negedge clk);
    host.cmd_type     = 2'(typ);
    host.target_track = 7'(tgt);
    host.step_rate    = 2'(rate);
    host.spinup_en    = spin[0];
    host.verify       = ver[0];
    host.cmd_start    = 1'b1;
    @(negedge clk);
    host.cmd_start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int n, output int t);
    n = 0;
    while (host.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, host.done, 1);
    check({tag, "_busy_low_at_done"}, host.busy, 0);
    t = cyc;
    @(negedge clk);
    check({tag, "_done_1cyc"}, host.done, 0);
  endtask

  task automatic check_pulses(input string tag, input int base, input int np, input int dir_in, input int per);
    check({tag, "_npulse"}, rt.size() - base, np);
    for (int k = 0; k < np && base + k < rt.size(); k++) begin
      check({tag, "_dir"}, rd[base + k], dir_in);
      check({tag, "_width_seen"}, wq.size() > base + k, 1);
      if (wq.size() > base + k) check({tag, "_width"}, wq[base + k], PW);
      if (k > 0) check({tag, "_spacing"}, rt[base + k] - rt[base + k - 1], per);
    end
  endtask

  int base, n, t, b, mt, typ, rate, tgt, np, dirv, newt, errx, d, T;

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog cycle budget exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    host.cmd_start = 1'b0; host.cmd_type = '0; host.target_track = '0;
    host.step_rate = '0; host.spinup_en = 1'b0; host.verify = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_motor", fd_motor_on, 0);
    check("rst_select", fd_select, 0);
    check("rst_busy", host.busy, 0);
    check("rst_track", host.track_reg, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_step", {fd_step_in, fd_step_out}, 0);
    check("post_rst_done", host.done, 0);
    mt = 0;

    // Motor off, spin-up enabled, seek 0 -> 2.
    base = rt.size();
    start_cmd(1, 2, 2, 1, 0);
    check("spin_motor_at_once", fd_motor_on, 1);
    check("spin_select", fd_select, 1);
    check("spin_busy", host.busy, 1);
    repeat (100) @(negedge clk);
    check("spin_no_pulse_before_index", rt.size() - base, 0);
    idx_run = 1'b1;
    n = 0;
    while (rt.size() == base && n < 1000) begin @(negedge clk); n++; end
    idx_run = 1'b0;
    check("spin_pulse_seen", rt.size() > base, 1);
    if (rt.size() > base) check("spin_index_before_pulse", ri[base], 6);
    wait_done("spin", 6000, n, t);
    check_pulses("spin", base, 2, 0, per_of(2));
    check("spin_track", host.track_reg, 2);
    mt = 2;

    // Idle spin-down after MOTOR_OFF_INDEX index edges.
    b = idx_rises;
    idx_run = 1'b1;
    n = 0;
    while (idx_rises < b + 8 && n < 2000) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    check("idle_motor_on_after_8", fd_motor_on, 1);
    while (idx_rises < b + 9 && n < 2000) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    check("idle_idx9_reached", idx_rises >= b + 9, 1);
    check("idle_motor_off_after_9", fd_motor_on, 0);
    check("idle_select_off", fd_select, 0);
    idx_run = 1'b0;

    // Seek to the current track: no pulse, quick completion.
    base = rt.size();
    start_cmd(1, mt, 2, 0, 0);
    wait_done("seek_same", 20, n, t);
    check("seek_same_fast", n <= 4, 1);
    check("seek_same_npulse", rt.size() - base, 0);
    check("seek_same_track", host.track_reg, mt);

    // Restore, head 3 tracks out, rate 0: three step_in pulses.
    sync_head(3);
    base = rt.size();
    start_cmd(0, 0, 0, 0, 0);
    wait_done("restore3", 3 * per_of(0) + 500, n, t);
    check_pulses("restore3", base, 3, 1, per_of(0));
    check("restore3_track", host.track_reg, 0);
    check("restore3_err", host.err_track0, 0);
    mt = 0;

    // Step in while already on track 0: no pulse.
    base = rt.size();
    start_cmd(2, 0, 2, 0, 0);
    wait_done("stepin_t0", 50, n, t);
    check("stepin_t0_npulse", rt.size() - base, 0);
    check("stepin_t0_track", host.track_reg, 0);

    // Seek 0 -> 3 at rate 3 with a stray cmd_start while busy.
    base = rt.size();
    start_cmd(1, 3, 3, 0, 0);
    repeat (100) @(negedge clk);
    host.cmd_type = 2'd0;
    host.cmd_start = 1'b1;
    @(negedge clk);
    host.cmd_start = 1'b0;
    wait_done("seek3", 3 * per_of(3) + 500, n, t);
    check_pulses("seek3", base, 3, 0, per_of(3));
    check("seek3_track", host.track_reg, 3);
    check("seek3_err", host.err_track0, 0);
    mt = 3;

    // Restore that never sees track 0.
    trk0_block = 1'b1;
    base = rt.size();
    start_cmd(0, 0, 2, 0, 0);
    wait_done("rest_fail", LIMIT * per_of(2) + 500, n, t);
    check_pulses("rest_fail", base, LIMIT, 1, per_of(2));
    check("rest_fail_err", host.err_track0, 1);
    check("rest_fail_track_kept", host.track_reg, mt);
    trk0_block = 1'b0;
    sync_head(mt);
    repeat (20) @(negedge clk);
    check("rest_fail_err_sticky", host.err_track0, 1);
    start_cmd(1, mt, 2, 0, 0);
    check("err_cleared_at_start", host.err_track0, 0);
    wait_done("err_clear", 50, n, t);

    // Random commands against the head model.
    for (int i = 0; i < 5; i++) begin
      typ  = $urandom_range(0, 3);
      rate = $urandom_range(2, 3);
      tgt  = mt + $urandom_range(0, 4) - 2;
      if (tgt < 0) tgt = 0;
      errx = 0;
      dirv = 0;
      case (typ)
        0: begin
          dirv = 1;
          if (mt <= LIMIT) begin np = mt; newt = 0; end
          else begin np = LIMIT; newt = mt; errx = 1; end
        end
        1: begin
          np = (tgt > mt) ? tgt - mt : mt - tgt;
          dirv = (tgt < mt) ? 1 : 0;
          newt = tgt;
        end
        2: begin
          dirv = 1;
          if (mt == 0) begin np = 0; newt = 0; end
          else begin np = 1; newt = mt - 1; end
        end
        default: begin np = 1; newt = mt + 1; end
      endcase
      base = rt.size();
      start_cmd(typ, tgt, rate, 0, 0);
      wait_done("rnd", np * per_of(rate) + 500, n, t);
      check_pulses("rnd", base, np, dirv, per_of(rate));
      check("rnd_track", host.track_reg, newt);
      check("rnd_err_track0", host.err_track0, errx);
      check("rnd_err_not_ready", host.err_not_ready, 0);
      mt = newt;
      sync_head(mt);
    end

    // Position to track 5 for the verify cases.
    start_cmd(1, 5, 2, 0, 0);
    wait_done("to5", 10 * per_of(2) + 500, n, t);
    check("to5_track", host.track_reg, 5);
    mt = 5;
    sync_head(mt);

    // Seek 5 -> 6 with verify, drive never ready.
    T = per_of(2);
    fd_ready = 1'b0;
    idx_run = 1'b1;
    base = rt.size();
    start_cmd(1, 6, 2, 0, 1);
    wait_done("vfail", T + SETTLE + 6 * IDX_PER + 200, n, t);
    idx_run = 1'b0;
    check_pulses("vfail", base, 1, 0, T);
    check("vfail_err", host.err_not_ready, 1);
    check("vfail_track", host.track_reg, 6);
    if (rt.size() > base) begin
      d = t - rt[base];
      check("vfail_lat_lo", d >= T + SETTLE + 4 * IDX_PER - 10, 1);
      check("vfail_lat_hi", d <= T + SETTLE + 5 * IDX_PER + 20, 1);
    end

    // Seek 6 -> 7 with verify, drive ready.
    fd_ready = 1'b1;
    base = rt.size();
    start_cmd(1, 7, 2, 0, 1);
    check("vpass_err_cleared", host.err_not_ready, 0);
    wait_done("vpass", T + SETTLE + 200, n, t);
    check_pulses("vpass", base, 1, 0, T);
    check("vpass_err", host.err_not_ready, 0);
    check("vpass_track", host.track_reg, 7);
    if (rt.size() > base) begin
      d = t - rt[base];
      check("vpass_lat_lo", d >= T + SETTLE - 3, 1);
      check("vpass_lat_hi", d <= T + SETTLE + 5, 1);
    end
    mt = 7;

    // Reset in the middle of a step pulse.
    start_cmd(3, 0, 2, 0, 0);
    n = 0;
    while (fd_step_out !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("midpulse_seen", fd_step_out, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_async_step_out", fd_step_out, 0);
    check("rst_async_step_in", fd_step_in, 0);
    check("rst_async_busy", host.busy, 0);
    check("rst_async_track", host.track_reg, 0);
    check("rst_async_motor", fd_motor_on, 0);
    @(negedge clk);
    reset = 1'b0;
    base = rt.size();
    repeat (100) @(negedge clk);
    check("rst_no_resume", rt.size() - base, 0);
    check("rst_idle_busy", host.busy, 0);

    check("never_both_steps", both_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
